// File: rtl/ising_result_reader.sv
// Result consumer for the ising_machine: it quantizes the final oscillator phases into spins,
// accumulates the Ising energy over the upper triangle of J, and offers both on a valid/ready port.
module ising_result_reader #(
   parameter int N              = 16,
   parameter int fractionalBits = 16,
   parameter int dataWidth      = 32,
   parameter int HALF_PI        = 102944
) (
   input  logic                        clk,
   input  logic                        n_rst,
   input  logic                        done_in,
   input  logic [N*dataWidth-1:0]      finalPhases,
   input  logic [N*N*dataWidth-1:0]    couplingMatrix,
   input  logic                        result_ready,
   output logic                        result_valid,
   output logic [N-1:0]                spins,
   output logic [63:0]                 energy,
   output logic                        busy,
   output logic                        overrun
);

   localparam int IW = $clog2(N);
   localparam logic [dataWidth:0] HALF_PI_W = (dataWidth+1)'(HALF_PI);

   if (N < 2 || N > 64 || fractionalBits >= dataWidth || dataWidth > 64) begin : g_bad_cfg
      $error("ising_result_reader: unsupported parameter set");
   end

   typedef enum logic [1:0] {S_IDLE, S_QUANT, S_ACCUM, S_HOLD} state_t;

   state_t                      state_q, state_d;
   logic signed [dataWidth-1:0] phase_q [N];
   logic signed [dataWidth-1:0] coef_m  [N][N];
   logic signed [dataWidth-1:0] coef_sel;
   logic signed [63:0]          coef_ext;
   logic signed [63:0]          acc_q, acc_d;
   logic [IW-1:0]               i_q, i_d, j_q, j_d;
   logic [N-1:0]                spin_q, spin_d;
   logic [N-1:0]                spins_q;
   logic [63:0]                 energy_q;
   logic                        valid_q, overrun_q;
   logic                        last_pair;
   logic                        cap_en, quant_en, accum_en, publish_en, xfer_en;

   // |v| in one extra bit so the most-negative phase stays positive.
   function automatic logic [dataWidth:0] abs_ext(input logic signed [dataWidth-1:0] v);
      logic signed [dataWidth:0] e;
      e = {v[dataWidth-1], v};
      return e[dataWidth] ? -e : e;
   endfunction

   for (genvar r = 0; r < N; r++) begin : g_row
      for (genvar c = 0; c < N; c++) begin : g_col
         assign coef_m[r][c] = couplingMatrix[(r*N+c)*dataWidth +: dataWidth];
      end
   end

   assign coef_sel  = coef_m[i_q][j_q];
   assign coef_ext  = {{(64-dataWidth){coef_sel[dataWidth-1]}}, coef_sel};
   assign last_pair = (i_q == IW'(N-2)) && (j_q == IW'(N-1));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (done_in) state_d = S_QUANT;
         S_QUANT: state_d = S_ACCUM;
         S_ACCUM: if (last_pair) state_d = S_HOLD;
         S_HOLD:  if (valid_q && result_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy       = (state_q != S_IDLE);
      cap_en     = (state_q == S_IDLE) && done_in;
      quant_en   = (state_q == S_QUANT);
      accum_en   = (state_q == S_ACCUM);
      publish_en = (state_q == S_HOLD) && !valid_q;
      xfer_en    = (state_q == S_HOLD) && valid_q && result_ready;
   end

   // Spin decision: strictly inside (-pi/2, pi/2) is +1.
   always_comb begin
      spin_d = '0;
      for (int n = 0; n < N; n++) begin
         spin_d[n] = (abs_ext(phase_q[n]) < HALF_PI_W);
      end
   end

   // Equal spins lower the energy by J, opposite spins raise it.
   always_comb begin
      acc_d = (spin_q[i_q] == spin_q[j_q]) ? (acc_q - coef_ext) : (acc_q + coef_ext);
      i_d   = i_q;
      j_d   = j_q;
      if (!last_pair) begin
         if (j_q == IW'(N-1)) begin
            i_d = i_q + 1'b1;
            j_d = i_q + IW'(2);
         end else begin
            j_d = j_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (cap_en) begin
         for (int n = 0; n < N; n++) begin
            phase_q[n] <= finalPhases[n*dataWidth +: dataWidth];
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         acc_q     <= '0;
         i_q       <= '0;
         j_q       <= '0;
         spin_q    <= '0;
         spins_q   <= '0;
         energy_q  <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (cap_en) acc_q <= '0;
         if (quant_en) begin
            spin_q <= spin_d;
            i_q    <= '0;
            j_q    <= IW'(1);
         end
         if (accum_en) begin
            acc_q <= acc_d;
            i_q   <= i_d;
            j_q   <= j_d;
         end
         if (publish_en) begin
            spins_q  <= spin_q;
            energy_q <= acc_q;
            valid_q  <= 1'b1;
         end
         if (xfer_en) valid_q <= 1'b0;
         if (done_in && busy) overrun_q <= 1'b1;
      end
   end

   assign result_valid = valid_q;
   assign spins        = spins_q;
   assign energy       = energy_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_ising_result_reader.sv
// Bench for ising_result_reader: fixed vector table, randomized runs against a spin/energy model,
// and hand sequences for back-pressure, overrun, asynchronous reset and the N=2 corner.
module tb_ising_result_reader;
   localparam int N  = 16;
   localparam int DW = 32;
   localparam int HP = 102944;
   localparam int PI = 205887;

   logic              clk = 1'b0;
   logic              n_rst = 1'b0;
   logic              done_in = 1'b0;
   logic              result_ready = 1'b0;
   logic [N*DW-1:0]   finalPhases = '0;
   logic [N*N*DW-1:0] couplingMatrix = '0;
   logic              result_valid, busy, overrun;
   logic [N-1:0]      spins;
   logic [63:0]       energy;

   logic              done2 = 1'b0;
   logic [2*DW-1:0]   phases2 = '0;
   logic [4*DW-1:0]   coup2 = '0;
   logic              valid2, busy2, overrun2;
   logic [1:0]        spins2;
   logic [63:0]       energy2;

   ising_result_reader #(.N(N)) dut (
      .clk(clk), .n_rst(n_rst), .done_in(done_in), .finalPhases(finalPhases),
      .couplingMatrix(couplingMatrix), .result_ready(result_ready), .result_valid(result_valid),
      .spins(spins), .energy(energy), .busy(busy), .overrun(overrun));

   ising_result_reader #(.N(2)) dut2 (
      .clk(clk), .n_rst(n_rst), .done_in(done2), .finalPhases(phases2),
      .couplingMatrix(coup2), .result_ready(1'b1), .result_valid(valid2),
      .spins(spins2), .energy(energy2), .busy(busy2), .overrun(overrun2));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int ph [N];
   int jm [N][N];

   typedef struct {
      int          mode;
      int          juni;
      int          oi, oj, ov;
      logic [15:0] sp;
      longint      en;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0d (0x%0h) want=%0d (0x%0h)", name, $signed(act), act, $signed(exp), exp);
      end
   endtask

   task automatic pack();
      for (int n = 0; n < N; n++) finalPhases[n*DW +: DW] = ph[n];
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) couplingMatrix[(r*N+c)*DW +: DW] = jm[r][c];
   endtask

   task automatic set_mode(input int mode, input int juni);
      for (int n = 0; n < N; n++) ph[n] = 0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) jm[r][c] = juni;
      case (mode)
         1: for (int n = 1; n < N; n += 2) ph[n] = PI;
         2: begin
            ph[0] = HP - 1; ph[1] = HP; ph[2] = -HP; ph[3] = -HP + 1; ph[4] = 32'h8000_0000;
         end
         3: ph[7] = PI;
         default: ;
      endcase
   endtask

   // Reference: spin from |phase| vs pi/2, energy as -sum over i<j of J*si*sj.
   function automatic void model(output logic [N-1:0] sp, output longint en);
      longint a;
      en = 0;
      for (int n = 0; n < N; n++) begin
         a = ph[n];
         if (a < 0) a = -a;
         sp[n] = (a < HP);
      end
      for (int r = 0; r < N; r++)
         for (int c = r + 1; c < N; c++)
            en -= longint'(jm[r][c]) * (sp[r] ? 1 : -1) * (sp[c] ? 1 : -1);
   endfunction

   task automatic start_run();
      @(negedge clk);
      done_in = 1'b1;
      @(posedge clk);
      #1 done_in = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (result_valid !== 1'b1 && lat < 400) begin
         @(posedge clk);
         #1 lat++;
      end
      if (result_valid !== 1'b1) chk("valid_timeout", 64'(result_valid), 64'd1);
   endtask

   task automatic run_check(input string name, input logic [15:0] sp, input longint en);
      int lat;
      pack();
      result_ready = 1'b1;
      start_run();
      wait_valid(lat);
      chk({name, "_latency"}, 64'(lat), 64'd122);
      chk({name, "_spins"}, 64'(spins), 64'(sp));
      chk({name, "_energy"}, energy, en);
      @(posedge clk);
      #1;
      chk({name, "_valid_after"}, 64'(result_valid), 64'd0);
      chk({name, "_busy_after"}, 64'(busy), 64'd0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      n_rst = 1'b0;
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
   endtask

   initial begin
      logic [N-1:0] msp, hsp;
      longint       men;
      logic [63:0]  hen;
      int           lat, stall;

      vecs[0] = '{0, 65536, -1, 0, 0, 16'hFFFF, -64'sd7864320};
      vecs[1] = '{1, 65536, -1, 0, 0, 16'h5555, 64'sd524288};
      vecs[2] = '{2, 0, -1, 0, 0, 16'hFFE9, 64'sd0};
      vecs[3] = '{3, 0, 3, 7, -65536, 16'hFF7F, -64'sd65536};
      vecs[4] = '{0, 0, 3, 7, -65536, 16'hFFFF, 64'sd65536};
      vecs[5] = '{0, 0, 7, 3, 12345, 16'hFFFF, 64'sd0};
      vecs[6] = '{0, 0, 5, 5, 777, 16'hFFFF, 64'sd0};
      vecs[7] = '{1, 0, 0, 15, 1048576, 16'h5555, 64'sd1048576};
      vecs[8] = '{1, 0, 14, 15, 3, 16'h5555, 64'sd3};

      #3;
      chk("rst_valid", 64'(result_valid), 64'd0);
      chk("rst_spins", 64'(spins), 64'd0);
      chk("rst_energy", energy, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_overrun", 64'(overrun), 64'd0);
      @(negedge clk);
      n_rst = 1'b1;

      for (int v = 0; v < 9; v++) begin
         set_mode(vecs[v].mode, vecs[v].juni);
         if (vecs[v].oi >= 0) jm[vecs[v].oi][vecs[v].oj] = vecs[v].ov;
         run_check($sformatf("vec%0d", v), vecs[v].sp, vecs[v].en);
      end

      for (int t = 0; t < 25; t++) begin
         for (int n = 0; n < N; n++) begin
            case ($urandom_range(0, 5))
               0: ph[n] = HP;
               1: ph[n] = -HP;
               2: ph[n] = HP - 1;
               default: ph[n] = int'($urandom_range(0, 2*PI)) - PI;
            endcase
         end
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) jm[r][c] = int'($urandom);
         model(msp, men);
         pack();
         result_ready = 1'b0;
         start_run();
         wait_valid(lat);
         stall = $urandom_range(0, 4);
         repeat (stall) begin @(posedge clk); #1; end
         chk($sformatf("rnd%0d_spins", t), 64'(spins), 64'(msp));
         chk($sformatf("rnd%0d_energy", t), energy, men);
         result_ready = 1'b1;
         @(posedge clk);
         #1 chk($sformatf("rnd%0d_valid_after", t), 64'(result_valid), 64'd0);
         result_ready = 1'b0;
      end
      chk("no_spurious_overrun", 64'(overrun), 64'd0);

      // done_in on the transfer cycle: flagged as overrun, no new run
      set_mode(0, 65536);
      pack();
      start_run();
      wait_valid(lat);
      done_in = 1'b1;
      result_ready = 1'b1;
      @(posedge clk);
      #1 done_in = 1'b0;
      chk("xferdone_valid", 64'(result_valid), 64'd0);
      chk("xferdone_busy", 64'(busy), 64'd0);
      chk("xferdone_overrun", 64'(overrun), 64'd1);
      repeat (3) @(posedge clk);
      #1 chk("xferdone_no_restart", 64'(busy), 64'd0);
      result_ready = 1'b0;

      // back-pressure with done_in during HOLD
      apply_reset();
      chk("bp_overrun_cleared", 64'(overrun), 64'd0);
      set_mode(1, 65536);
      pack();
      start_run();
      wait_valid(lat);
      hsp = spins;
      hen = energy;
      chk("bp_spins", 64'(hsp), 64'h5555);
      for (int c = 0; c < 10; c++) begin
         done_in = (c == 3);
         @(posedge clk);
         #1;
         chk($sformatf("bp_hold%0d_valid", c), 64'(result_valid), 64'd1);
         chk($sformatf("bp_hold%0d_spins", c), 64'(spins), 64'(hsp));
         chk($sformatf("bp_hold%0d_energy", c), energy, hen);
      end
      done_in = 1'b0;
      chk("bp_overrun", 64'(overrun), 64'd1);
      result_ready = 1'b1;
      @(posedge clk);
      #1 chk("bp_valid_after", 64'(result_valid), 64'd0);
      repeat (5) @(posedge clk);
      #1;
      chk("bp_single_xfer", 64'(result_valid), 64'd0);
      chk("bp_idle", 64'(busy), 64'd0);
      chk("bp_outputs_kept", energy, 64'sd524288);

      // asynchronous reset in the middle of ACCUM
      set_mode(0, 65536);
      pack();
      start_run();
      repeat (60) @(posedge clk);
      #2 chk("midrun_busy", 64'(busy), 64'd1);
      n_rst = 1'b0;
      #1;
      chk("arst_valid", 64'(result_valid), 64'd0);
      chk("arst_spins", 64'(spins), 64'd0);
      chk("arst_energy", energy, 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_overrun", 64'(overrun), 64'd0);
      @(negedge clk);
      n_rst = 1'b1;
      run_check("rerun", 16'hFFFF, -64'sd7864320);

      // N=2: a single ACCUM cycle, lower triangle and diagonal ignored
      for (int k = 0; k < 2; k++) begin
         phases2 = {(k == 0) ? 32'(PI) : 32'd0, 32'd0};
         coup2   = {32'd5, 32'd999999, 32'd1000, 32'd5};
         @(negedge clk);
         done2 = 1'b1;
         @(posedge clk);
         #1 done2 = 1'b0;
         lat = 0;
         while (valid2 !== 1'b1 && lat < 50) begin
            @(posedge clk);
            #1 lat++;
         end
         chk($sformatf("n2_%0d_latency", k), 64'(lat), 64'd3);
         chk($sformatf("n2_%0d_spins", k), 64'(spins2), (k == 0) ? 64'd1 : 64'd3);
         chk($sformatf("n2_%0d_energy", k), energy2, (k == 0) ? 64'sd1000 : -64'sd1000);
         @(posedge clk);
         #1 chk($sformatf("n2_%0d_valid_after", k), 64'(valid2), 64'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1);
   end

endmodule
